// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg
//   Shared definitions for the counter sequencing controller: FSM state
//   encoding and default widths for the count register and pass counter.
package counter_ctrl_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_REP_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/counter_ctrl_core.sv
// counter_core
//   WIDTH-bit up counter that runs 0..i_limit and folds back to 0 when it
//   advances from i_limit. Clear has priority over enable.
//   Ports:
//     clk        rising-edge clock
//     reset      asynchronous active-low reset
//     i_clear    force count to 0 on next edge
//     i_enable   advance count on next edge
//     i_limit    terminal count
//     o_q        current count
//     o_at_limit combinational q == limit
module counter_core
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_limit,
  output logic [WIDTH-1:0] o_q,
  output logic             o_at_limit
);

  logic [WIDTH-1:0] r_q;

  assign o_q        = r_q;
  assign o_at_limit = (r_q == i_limit);

  // At the terminal count the next advance returns to 0; with limit at the
  // top of the range this is the ordinary binary rollover.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= '0;
    end else if (i_clear) begin
      r_q <= '0;
    end else if (i_enable) begin
      if (o_at_limit) r_q <= '0;
      else            r_q <= r_q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// counter_ctrl
//   Sequencing controller around counter_core. Accepts a configuration
//   (limit, pass count, auto mode) through a valid/ready handshake, runs the
//   count through the configured passes on each tick, pulses wrap on every
//   limit->0 fold, and reports completion through a done valid/ready pair.
//   Ports:
//     clk         rising-edge clock
//     reset       asynchronous active-low reset
//     cfg_valid   configuration offered
//     cfg_ready   configuration accepted (IDLE only)
//     cfg_limit   terminal count, pass runs 0..cfg_limit
//     cfg_reps    passes minus one
//     cfg_auto    run indefinitely, ignore cfg_reps
//     tick        count-advance strobe
//     abort       stop a run and return to IDLE
//     q           current count
//     wrap        one-cycle pulse after a limit->0 fold
//     busy        run in progress
//     done_valid  run finished, held until accepted
//     done_ready  consumer accepts done
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int REP_W = DEF_REP_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_limit,
  input  logic [REP_W-1:0] cfg_reps,
  input  logic             cfg_auto,
  input  logic             tick,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             wrap,
  output logic             busy,
  output logic             done_valid,
  input  logic             done_ready
);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_limit;
  logic [REP_W-1:0] r_reps;
  logic             r_auto;
  logic [REP_W-1:0] r_pass;
  logic [REP_W-1:0] w_pass_next;
  logic             r_wrap;
  logic             r_busy;
  logic             r_done_valid;

  logic             w_load;
  logic             w_clear;
  logic             w_adv;
  logic             w_at_limit;
  logic             w_wrap_evt;

  // Abort removes the advance entirely, so it also suppresses the wrap pulse
  // and the final-pass transition of a simultaneous tick.
  assign w_adv      = (r_state == RUN) && tick && !abort;
  assign w_wrap_evt = w_adv && w_at_limit;

  counter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_clear),
    .i_enable  (w_adv),
    .i_limit   (r_limit),
    .o_q       (q),
    .o_at_limit(w_at_limit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pass_next  = r_pass;
    w_load       = 1'b0;
    w_clear      = 1'b0;
    case (r_state)
      IDLE: begin
        if (cfg_valid) begin
          w_load       = 1'b1;
          w_clear      = 1'b1;
          w_pass_next  = '0;
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          w_clear      = 1'b1;
          w_state_next = IDLE;
        end else if (w_wrap_evt) begin
          if (r_auto) begin
            // Auto mode never finishes; the pass count just sticks at its
            // maximum rather than rolling over.
            if (r_pass != '1) w_pass_next = r_pass + REP_W'(1);
          end else if (r_pass == r_reps) begin
            w_state_next = DONE;
          end else begin
            w_pass_next = r_pass + REP_W'(1);
          end
        end
      end
      DONE: begin
        w_clear = 1'b1;
        if (done_ready) w_state_next = IDLE;
      end
      default: begin
        w_clear      = 1'b1;
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_limit <= '0;
      r_reps  <= '0;
      r_auto  <= 1'b0;
    end else if (w_load) begin
      r_limit <= cfg_limit;
      r_reps  <= cfg_reps;
      r_auto  <= cfg_auto;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pass <= '0;
    end else begin
      r_pass <= w_pass_next;
    end
  end

  // Moore outputs are registered from the next state so they line up with
  // the state register; the final wrap and done_valid rise together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wrap       <= 1'b0;
      r_busy       <= 1'b0;
      r_done_valid <= 1'b0;
    end else begin
      r_wrap       <= w_wrap_evt;
      r_busy       <= (w_state_next == RUN);
      r_done_valid <= (w_state_next == DONE);
    end
  end

  assign cfg_ready  = (r_state == IDLE);
  assign wrap       = r_wrap;
  assign busy       = r_busy;
  assign done_valid = r_done_valid;

endmodule

// File: tb/tb_counter_ctrl.sv
module tb_counter_ctrl;

  logic       clk;
  logic       reset;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [3:0] cfg_limit;
  logic [3:0] cfg_reps;
  logic       cfg_auto;
  logic       tick;
  logic       abort;
  logic [3:0] q;
  logic       wrap;
  logic       busy;
  logic       done_valid;
  logic       done_ready;

  counter_ctrl #(
    .WIDTH(4),
    .REP_W(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_limit (cfg_limit),
    .cfg_reps  (cfg_reps),
    .cfg_auto  (cfg_auto),
    .tick      (tick),
    .abort     (abort),
    .q         (q),
    .wrap      (wrap),
    .busy      (busy),
    .done_valid(done_valid),
    .done_ready(done_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] q;
    logic       wrap;
    logic       busy;
    logic       dv;
    logic       cr;
  } exp_t;

  exp_t sb_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: tracks total ticks taken in the current run.
  int m_state = 0;   // 0 idle, 1 run, 2 done
  int m_n     = 0;
  int m_limit = 0;
  int m_reps  = 0;
  bit m_auto  = 0;
  bit m_wrap  = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
    n_cmp++;
    assert (obs === want)
    else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  task automatic step(input logic cv, input logic [3:0] lim, input logic [3:0] rp,
                      input logic au, input logic tk, input logic ab, input logic dr);
    exp_t e;
    exp_t g;
    @(negedge clk);
    cfg_valid  = cv;
    cfg_limit  = lim;
    cfg_reps   = rp;
    cfg_auto   = au;
    tick       = tk;
    abort      = ab;
    done_ready = dr;
    m_wrap = 0;
    case (m_state)
      0: if (cv) begin
        m_limit = int'(lim);
        m_reps  = int'(rp);
        m_auto  = au;
        m_n     = 0;
        m_state = 1;
      end
      1: if (ab) begin
        m_state = 0;
        m_n     = 0;
      end else if (tk) begin
        m_n++;
        if (m_n % (m_limit + 1) == 0) m_wrap = 1;
        if (!m_auto && m_n == (m_limit + 1) * (m_reps + 1)) m_state = 2;
      end
      2: if (dr) m_state = 0;
      default: m_state = 0;
    endcase
    e.q    = (m_state == 1) ? 4'(m_n % (m_limit + 1)) : 4'd0;
    e.wrap = m_wrap;
    e.busy = (m_state == 1);
    e.dv   = (m_state == 2);
    e.cr   = (m_state == 0);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    g = sb_q.pop_front();
    chk("q",          {4'd0, q},          {4'd0, g.q});
    chk("wrap",       {7'd0, wrap},       {7'd0, g.wrap});
    chk("busy",       {7'd0, busy},       {7'd0, g.busy});
    chk("done_valid", {7'd0, done_valid}, {7'd0, g.dv});
    chk("cfg_ready",  {7'd0, cfg_ready},  {7'd0, g.cr});
  endtask

  initial begin
    reset = 1'b0;
    cfg_valid = 0; cfg_limit = 0; cfg_reps = 0; cfg_auto = 0;
    tick = 0; abort = 0; done_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q",   {4'd0, q}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_cfg_ready", {7'd0, cfg_ready}, 8'd1);
    chk("rst_done_valid", {7'd0, done_valid}, 8'd0);
    @(negedge clk);
    reset = 1'b1;

    // Idle with tick and abort: both ignored.
    step(0, 4'd0, 4'd0, 0, 1, 1, 0);

    // Single pass, limit 3.
    step(1, 4'd3, 4'd0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 4'd0, 4'd0, 0, 1, 0, 0);
    step(0, 4'd0, 4'd0, 0, 0, 0, 1);

    // Multi-pass with tick every other cycle.
    step(1, 4'd2, 4'd2, 0, 0, 0, 0);
    for (int i = 0; i < 18; i++) step(0, 4'd0, 4'd0, 0, logic'(i % 2), 0, 0);
    step(0, 4'd0, 4'd0, 0, 0, 1, 0);   // abort ignored in DONE
    step(0, 4'd0, 4'd0, 0, 0, 0, 1);

    // limit 0: every tick wraps.
    step(1, 4'd0, 4'd4, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 4'd0, 4'd0, 0, 1, 0, 0);
    step(0, 4'd0, 4'd0, 0, 0, 0, 1);

    // limit 15, auto: natural rollover, never done.
    step(1, 4'd15, 4'd0, 1, 0, 0, 0);
    for (int i = 0; i < 40; i++) step(0, 4'd0, 4'd0, 0, 1, 0, 1);
    step(0, 4'd0, 4'd0, 0, 1, 1, 0);

    // Auto with limit 0: pass counter runs past its range without effect.
    step(1, 4'd0, 4'd2, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 4'd0, 4'd0, 0, 1, 0, 0);
    step(0, 4'd0, 4'd0, 0, 0, 1, 0);

    // Abort on the final wrap tick.
    step(1, 4'd1, 4'd0, 0, 0, 0, 0);
    step(0, 4'd0, 4'd0, 0, 1, 0, 0);
    step(0, 4'd0, 4'd0, 0, 1, 1, 0);
    step(0, 4'd0, 4'd0, 0, 1, 0, 0);

    // Handshake: done held, cfg offered but not taken, then accepted.
    step(1, 4'd1, 4'd0, 0, 0, 0, 0);
    step(0, 4'd0, 4'd0, 0, 1, 0, 0);
    step(0, 4'd0, 4'd0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 4'd5, 4'd1, 0, 0, 0, 0);
    step(1, 4'd5, 4'd1, 0, 0, 0, 1);
    step(1, 4'd5, 4'd1, 0, 0, 0, 0);
    step(0, 4'd0, 4'd0, 0, 1, 0, 0);
    step(0, 4'd0, 4'd0, 0, 0, 1, 0);

    // Asynchronous reset mid-count at q=7.
    step(1, 4'd10, 4'd0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 4'd0, 4'd0, 0, 1, 0, 0);
    @(negedge clk);
    tick = 0;
    #2 reset = 1'b0;
    #1;
    chk("arst_q",         {4'd0, q},          8'd0);
    chk("arst_busy",      {7'd0, busy},       8'd0);
    chk("arst_cfg_ready", {7'd0, cfg_ready},  8'd1);
    chk("arst_wrap",      {7'd0, wrap},       8'd0);
    m_state = 0;
    m_n     = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    step(0, 4'd0, 4'd0, 0, 1, 0, 0);
    step(0, 4'd0, 4'd0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
Sequencing controller for the team's 4-bit free-running counter datapath. It owns a WIDTH-bit count register and runs it through a configured number of passes from 0 to a programmable limit. It advances on an external tick, pulses on every wrap, and reports completion through a valid/ready done handshake. It sits between a configuring master (CPU/sequencer) and any logic consuming q and wrap.

Parameters:
WIDTH, 4, count register width
REP_W, 4, width of pass-count field

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
cfg_valid  in  1  configuration offered
cfg_ready  out  1  controller can accept configuration (high only in IDLE)
cfg_limit  in  WIDTH  terminal count; pass runs 0..cfg_limit
cfg_reps  in  REP_W  passes minus one (0 = one pass)
cfg_auto  in  1  1 = run indefinitely, ignore cfg_reps
tick  in  1  count-advance strobe, sampled each clk
abort  in  1  stop run, return to IDLE
q  out  WIDTH  current count
wrap  out  1  one-cycle pulse when q wraps limit->0
busy  out  1  state is RUN
done_valid  out  1  run finished, held until accepted
done_ready  in  1  consumer accepts done

Behaviour:
- Reset (reset=0, async): state=IDLE, q=0, wrap=0, busy=0, done_valid=0, cfg_ready=1 on deassert; latched limit/reps/auto=0, pass counter=0. Reset mid-run discards the run, no done issued.
- States: IDLE, RUN, DONE. Registered Moore outputs except cfg_ready = (state==IDLE).
- IDLE: cfg_valid&cfg_ready at edge T latches cfg_limit/cfg_reps/cfg_auto, clears pass counter, q=0; RUN from T+1 (busy=1 at T+1). tick ignored in IDLE.
- RUN, tick=1, abort=0:
  - q<limit: q<=q+1.
  - q==limit: q<=0, wrap=1 next cycle for exactly one cycle. If cfg_auto=0 and pass counter==reps: go DONE. Otherwise pass counter+1, stay RUN.
- RUN, tick=0: hold q, wrap=0.
- abort=1 in RUN: next state IDLE, q<=0, no wrap, no done. abort wins over a simultaneous tick or final wrap.
- abort in IDLE or DONE: ignored.
- DONE: busy=0, done_valid=1, q=0. Stay until done_valid&done_ready, then IDLE next cycle. Final wrap pulse and done_valid assert in the same cycle.
- limit=0: every tick is a wrap, q stays 0.
- limit=2^WIDTH-1: natural binary wrap, no overflow special case.
- Pass counter is REP_W bits and saturates only in auto mode: it freezes, so no pass-count wrap.
- Total ticks for a non-auto run = (limit+1)*(reps+1). Run exit latency: DONE one cycle after the final tick edge.
- cfg_valid with cfg_ready=0 is not consumed; the master must hold it.
- All arithmetic is unsigned, modulo 2^WIDTH for q.

Decomposition:
- Shared package counter_ctrl_pkg: state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2), default WIDTH/REP_W constants.
- One natural sub-module: counter_core. It is the WIDTH-bit counter with clear and enable plus a terminal-compare output (q==limit). The FSM and pass counter stay in counter_ctrl.

Test Plan:
- Reset: reset=0 mid-count at q=7 -> q=0, busy=0, cfg_ready=1 immediately (async), no done_valid after release.
- Single pass: limit=3, reps=0, auto=0, tick every cycle -> q=1,2,3,0. wrap and done_valid both high 1 cycle after the 4th tick. done_ready=1 -> IDLE next cycle.
- Multi-pass with gaps: limit=2, reps=2, tick every other cycle -> 3 wrap pulses, done after 9 ticks, q holds on tick=0 cycles.
- Boundary limits: limit=0, reps=4 -> 5 consecutive wraps, q stays 0. limit=15, auto=1 -> q 15->0 wrap repeats indefinitely, never DONE.
- Abort: abort=1 with tick=1 on the final wrap tick (limit=1, reps=0, q=1) -> IDLE, q=0, no wrap, no done_valid.
- Handshake: hold done_ready=0 for 5 cycles -> done_valid stays 1, cfg_valid ignored (cfg_ready=0). Then done_ready=1 -> IDLE, and the next cfg is accepted the following cycle.
